// File: rtl/alu_regfile.sv
// Execution core of the 8-bit CPU datapath.
// Contains an 8 x 8-bit register file and an 8-bit ALU that share one data path.
//   - Two combinational read ports.
//   - One clocked write port, whose write data is the ALU result.
//   - Asynchronous active-high reset clears every register.
module alu_regfile (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       write_enable_i,
  input  logic [2:0] write_reg_i,
  input  logic [2:0] read_reg1_i,
  input  logic [2:0] read_reg2_i,
  input  logic [7:0] data2_i,
  input  logic [2:0] alu_op_i,
  output logic [7:0] regout1_o,
  output logic [7:0] regout2_o,
  output logic [7:0] alu_result_o,
  output logic       zero_o
);

  localparam logic [2:0] OP_FWD = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;

  logic [7:0] regs_q [8];
  logic [7:0] alu_d;
  logic       wr_en_d;

  // Asynchronous read ports. Registers are already cleared during reset,
  // so no extra masking is needed to read zero while reset is high.
  always_comb begin
    regout1_o = regs_q[read_reg1_i];
    regout2_o = regs_q[read_reg2_i];
  end

  // ALU: operand 1 is read port 1, operand 2 comes from the external muxes.
  // Reserved or unknown selects fall to the default arm and produce zero.
  always_comb begin
    alu_d = 8'h00;
    case (alu_op_i)
      OP_FWD:  alu_d = data2_i;
      OP_ADD:  alu_d = regout1_o + data2_i;
      OP_AND:  alu_d = regout1_o & data2_i;
      OP_OR:   alu_d = regout1_o | data2_i;
      default: alu_d = 8'h00;
    endcase
  end

  // Result and branch flag; zero is valid for every op, including reserved ones.
  always_comb begin
    alu_result_o = alu_d;
    zero_o       = ~|alu_d;
  end

  // An unknown enable is treated as no write.
  always_comb begin
    wr_en_d = (write_enable_i == 1'b1);
  end

  // One write per rising edge. There is no bypass: the new value appears on
  // the read ports only after the edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < 8; i++) regs_q[i] <= 8'h00;
    end else if (wr_en_d) begin
      regs_q[write_reg_i] <= alu_d;
    end
  end

endmodule

// File: tb/tb_alu_regfile.sv
// Self-checking bench for alu_regfile.
// Consists of three parts:
//   - a table of ALU/register vectors,
//   - hand-written reset and write-gating sequences,
//   - a randomized run checked against an array-based reference model.
module tb_alu_regfile;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       we = 1'b0;
  logic [2:0] wr = 3'd0;
  logic [2:0] rr1 = 3'd0;
  logic [2:0] rr2 = 3'd0;
  logic [7:0] d2 = 8'h00;
  logic [2:0] op = 3'd0;
  logic [7:0] ro1, ro2, res;
  logic       zero;

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] mdl [8];

  alu_regfile dut (
    .clk_i(clk), .rst_i(rst), .write_enable_i(we), .write_reg_i(wr),
    .read_reg1_i(rr1), .read_reg2_i(rr2), .data2_i(d2), .alu_op_i(op),
    .regout1_o(ro1), .regout2_o(ro2), .alu_result_o(res), .zero_o(zero)
  );

  always #10 clk = ~clk;

  function automatic logic [7:0] ref_alu(input logic [7:0] a, input logic [7:0] b,
                                         input logic [2:0] sel);
    int s;
    case (sel)
      3'd0: return b;
      3'd1: begin s = (int'(a) + int'(b)) % 256; return 8'(s); end
      3'd2: return a & b;
      3'd3: return a | b;
      default: return 8'h00;
    endcase
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  // Load a register through the FORWARD path and keep the model in step.
  task automatic load(input logic [2:0] r, input logic [7:0] v);
    @(negedge clk);
    rst = 1'b0; we = 1'b1; wr = r; op = 3'd0; d2 = v;
    @(posedge clk);
    #1;
    we = 1'b0;
    mdl[r] = v;
  endtask

  typedef struct {
    logic [2:0] rg;
    logic [7:0] val;
    logic [7:0] data2;
    logic [2:0] aop;
    logic [7:0] exp_res;
    logic       exp_zero;
    string      name;
  } vec_t;

  vec_t vecs [10];
  logic [7:0] e;

  initial begin
    for (int i = 0; i < 8; i++) mdl[i] = 8'h00;

    vecs[0] = '{3'd1, 8'hFF, 8'h01, 3'b001, 8'h00, 1'b1, "add_wrap"};
    vecs[1] = '{3'd1, 8'hFF, 8'h02, 3'b001, 8'h01, 1'b0, "add_wrap1"};
    vecs[2] = '{3'd2, 8'h09, 8'hF7, 3'b001, 8'h00, 1'b1, "sub_eq"};
    vecs[3] = '{3'd2, 8'h09, 8'hF8, 3'b001, 8'h01, 1'b0, "sub_ne"};
    vecs[4] = '{3'd4, 8'hF0, 8'h3C, 3'b010, 8'h30, 1'b0, "and"};
    vecs[5] = '{3'd4, 8'hF0, 8'h3C, 3'b011, 8'hFC, 1'b0, "or"};
    vecs[6] = '{3'd4, 8'hF0, 8'h3C, 3'b101, 8'h00, 1'b1, "rsvd101"};
    vecs[7] = '{3'd7, 8'h11, 8'h5A, 3'b000, 8'h5A, 1'b0, "fwd"};
    vecs[8] = '{3'd7, 8'h11, 8'hEE, 3'b111, 8'h00, 1'b1, "rsvd111"};
    vecs[9] = '{3'd0, 8'h80, 8'h80, 3'b001, 8'h00, 1'b1, "r0_add"};

    // Reset state.
    rst = 1'b1;
    #3;
    d2 = 8'h3C; op = 3'b000;
    #1;
    chk("rst_ro1", ro1, 8'h00);
    chk("rst_ro2", ro2, 8'h00);
    chk("rst_res", res, 8'h3C);
    chk("rst_zero", {7'd0, zero}, 8'h00);
    @(negedge clk);
    rst = 1'b0;

    // loadi / read-back.
    load(3'd3, 8'h05);
    rr1 = 3'd3;
    #1;
    chk("loadi_ro1", ro1, 8'h05);

    // Table-driven ALU vectors.
    for (int i = 0; i < 10; i++) begin
      load(vecs[i].rg, vecs[i].val);
      @(negedge clk);
      rr1 = vecs[i].rg; rr2 = vecs[i].rg; d2 = vecs[i].data2; op = vecs[i].aop;
      #1;
      chk({vecs[i].name, "_ro1"}, ro1, vecs[i].val);
      chk({vecs[i].name, "_ro2"}, ro2, vecs[i].val);
      chk({vecs[i].name, "_res"}, res, vecs[i].exp_res);
      chk({vecs[i].name, "_zero"}, {7'd0, zero}, {7'd0, vecs[i].exp_zero});
    end

    // Reset clear between edges: every register reads zero with no edge.
    for (int i = 0; i < 8; i++) load(3'(i), 8'hAA);
    @(negedge clk);
    rr1 = 3'd0; rr2 = 3'd1;
    #1;
    chk("pre_rst_ro1", ro1, 8'hAA);
    rst = 1'b1;
    for (int i = 0; i < 8; i += 2) begin
      rr1 = 3'(i); rr2 = 3'(i + 1);
      #1;
      chk("rstclr_ro1", ro1, 8'h00);
      chk("rstclr_ro2", ro2, 8'h00);
    end
    rst = 1'b0;
    for (int i = 0; i < 8; i++) mdl[i] = 8'h00;

    // A write with the enable low leaves the register unchanged.
    load(3'd5, 8'h33);
    @(negedge clk);
    we = 1'b0; wr = 3'd5; op = 3'd0; d2 = 8'hC4; rr1 = 3'd5;
    @(posedge clk);
    #1;
    chk("we0_hold", ro1, 8'h33);

    // A write while reset is high is blocked.
    @(negedge clk);
    rst = 1'b1; we = 1'b1; wr = 3'd6; d2 = 8'h42; rr1 = 3'd6;
    @(posedge clk);
    #1;
    chk("we_in_rst", ro1, 8'h00);
    @(negedge clk);
    rst = 1'b0; we = 1'b0;
    for (int i = 0; i < 8; i++) mdl[i] = 8'h00;

    // Reset released before an edge allows the write at that edge.
    @(negedge clk);
    we = 1'b1; wr = 3'd6; op = 3'd0; d2 = 8'h42; rr1 = 3'd6;
    @(posedge clk);
    #1;
    we = 1'b0;
    mdl[6] = 8'h42;
    chk("post_rst_wr", ro1, 8'h42);

    // Read during write: old value before the edge, new value after.
    // The add feeds back through read port 1, but only one write happens per edge.
    load(3'd2, 8'h10);
    @(negedge clk);
    we = 1'b1; wr = 3'd2; rr1 = 3'd2; op = 3'b001; d2 = 8'h05;
    #1;
    chk("rdw_old", ro1, 8'h10);
    chk("rdw_res_old", res, 8'h15);
    @(posedge clk);
    #1;
    we = 1'b0;
    mdl[2] = 8'h15;
    chk("rdw_new", ro1, 8'h15);
    chk("rdw_res_new", res, 8'h1A);
    #5;
    chk("rdw_single", ro1, 8'h15);

    // Randomized stimulus against the array model.
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 29) == 0);
      we  = 1'($urandom);
      wr  = 3'($urandom);
      rr1 = 3'($urandom);
      rr2 = 3'($urandom);
      d2  = 8'($urandom);
      op  = 3'($urandom_range(0, 7));
      if (rst) for (int k = 0; k < 8; k++) mdl[k] = 8'h00;
      #1;
      e = ref_alu(mdl[rr1], d2, op);
      chk("rnd_ro1", ro1, mdl[rr1]);
      chk("rnd_ro2", ro2, mdl[rr2]);
      chk("rnd_res", res, e);
      chk("rnd_zero", {7'd0, zero}, {7'd0, (e == 8'h00)});
      @(posedge clk);
      if (we && !rst) mdl[wr] = e;
    end
    @(negedge clk);
    rst = 1'b0; we = 1'b0;
    for (int i = 0; i < 8; i++) begin
      rr1 = 3'(i);
      #1;
      chk("final_reg", ro1, mdl[i]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
